// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-bus arbiter: FSM states, grant
// identifiers, the zero data word and the stall-request levels.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_IF  = 2'd1,
    ST_BUS_MEM = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GrantIF  = 1'b0,
    GrantMEM = 1'b1
  } grant_t;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Levels driven onto the stall request towards the pipeline control unit.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus-wait watchdog for mem_arbiter: counts unacknowledged bus cycles and
// flags expiry once TIMEOUT_CYCLES waits have elapsed.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] count;

  // Held at zero outside a bus cycle so every new cycle starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      count <= '0;
    end else if (!ack && count != Limit) begin
      count <= count + 1'b1;
    end
  end

  assign expired = busy && (count == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising IF fetches and MEM loads/stores onto one
// Wishbone-classic bus. Optional watchdog abort under MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                bus_cyc_o,
  output logic                bus_stb_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic                bus_err_o,
  output logic                stallreq_o,
  output state_t              dbg_state
);

  localparam int unsigned SelW = DATA_W / 8;

  state_t              state;
  grant_t              last_grant;
  logic                cyc;
  logic                we;
  logic [SelW-1:0]     sel;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                if_ack;
  logic                mem_ack;
  logic [DATA_W-1:0]   if_rdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                err;
  logic                abort;
  logic [DATA_W-1:0]   capture;

`ifdef MEM_ARB_TIMEOUT_EN
  logic in_bus;

  assign in_bus = (state == ST_BUS_IF) || (state == ST_BUS_MEM);

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .busy    (in_bus),
    .ack     (bus_ack_i),
    .expired (abort)
  );
`else
  assign abort = 1'b0;

  // The limit has no effect when the arbiter waits indefinitely.
  if (TIMEOUT_CYCLES == 0) begin : g_no_limit
  end
`endif

  // Stores and aborted cycles return zero; a coincident ack beats an abort.
  assign capture = (bus_ack_i && !we) ? bus_rdata_i : DATA_W'(ZeroWord);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GrantIF;
      cyc        <= 1'b0;
      we         <= 1'b0;
      sel        <= '0;
      addr       <= '0;
      wdata      <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      err        <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_req_i && (!if_req_i || last_grant == GrantIF)) begin
            cyc   <= 1'b1;
            we    <= mem_we_i;
            sel   <= mem_sel_i;
            addr  <= mem_addr_i;
            wdata <= mem_wdata_i;
            state <= ST_BUS_MEM;
          end else if (if_req_i) begin
            cyc   <= 1'b1;
            we    <= 1'b0;
            sel   <= '1;
            addr  <= if_addr_i;
            wdata <= DATA_W'(ZeroWord);
            state <= ST_BUS_IF;
          end
        end
        ST_BUS_IF, ST_BUS_MEM: begin
          if (bus_ack_i || abort) begin
            cyc   <= 1'b0;
            err   <= !bus_ack_i;
            state <= ST_DONE;
            if (state == ST_BUS_IF) begin
              if_ack     <= 1'b1;
              if_rdata   <= capture;
              last_grant <= GrantIF;
            end else begin
              mem_ack    <= 1'b1;
              mem_rdata  <= capture;
              last_grant <= GrantMEM;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus_cyc_o   = cyc;
  assign bus_stb_o   = cyc;
  assign bus_we_o    = we;
  assign bus_sel_o   = sel;
  assign bus_addr_o  = addr;
  assign bus_wdata_o = wdata;
  assign if_ack_o    = if_ack;
  assign mem_ack_o   = mem_ack;
  assign if_rdata_o  = if_rdata;
  assign mem_rdata_o = mem_rdata;
  assign bus_err_o   = err;
  assign dbg_state   = state;

  assign stallreq_o = ((if_req_i && !if_ack) || (mem_req_i && !mem_ack)) ? Stop : NoStop;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter; honours MEM_ARB_TIMEOUT_EN
// when choosing the expected behaviour of a never-acknowledged bus cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;
  logic        stallreq_o;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .stallreq_o(stallreq_o), .dbg_state(dbg_state)
  );

  // Clock and safety net
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench exceeded its time budget");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_bus(input string tag, input logic [31:0] a, input logic w,
                           input logic [3:0] s);
    check({tag, "_cyc"}, bus_cyc_o, 1'b1);
    check({tag, "_stb"}, bus_stb_o, 1'b1);
    check({tag, "_addr"}, bus_addr_o, a);
    check({tag, "_we"}, bus_we_o, w);
    check({tag, "_sel"}, bus_sel_o, s);
  endtask

  // Scoreboard state for the randomized phase
  logic [31:0] model_mem [16];
  logic [31:0] exp_q [$];
  bit          if_pend, mem_pend, on_bus, ack_due, free_prev, prev_if, prev_mem;
  bit          owner_mem, last_mem, free_this;
  int          wait_left;
  logic [31:0] if_a, m_a, m_wd, s_addr, s_wd, due_data, exp_if_rd, exp_mem_rd, rd;
  logic        m_we, s_we, exp_if_ack, exp_mem_ack;
  logic [3:0]  m_sel, s_sel, idx;

  initial begin
    // Reset values
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hffff_ffff;
    repeat (2) tick();
    check("rst_cyc", bus_cyc_o, 1'b0);
    check("rst_stb", bus_stb_o, 1'b0);
    check("rst_bus", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, '0);
    check("rst_acks", {if_ack_o, mem_ack_o, bus_err_o}, 3'b000);
    check("rst_rdata", {if_rdata_o, mem_rdata_o}, 64'h0);
    check("rst_state", dbg_state, ST_IDLE);
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    rst = 1'b0;
    tick();

    // IF read against a zero-wait slave
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    settle();
    check("if0_stall", stallreq_o, 1'b1);
    check("if0_stb", bus_stb_o, 1'b0);
    tick();
    check_bus("if1", 32'h0000_0100, 1'b0, 4'hf);
    check("if1_ack", if_ack_o, 1'b0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3421_0001;
    settle();
    check("if1_stall", stallreq_o, 1'b1);
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    check("if2_ack", if_ack_o, 1'b1);
    check("if2_rdata", if_rdata_o, 32'h3421_0001);
    check("if2_stb", bus_stb_o, 1'b0);
    settle();
    check("if2_stall", stallreq_o, 1'b0);
    if_req_i = 1'b0;
    tick();
    check("if3_ack", if_ack_o, 1'b0);
    check("if3_state", dbg_state, ST_IDLE);
    check("if3_hold", if_rdata_o, 32'h3421_0001);
    check("if3_stall", stallreq_o, 1'b0);

    // Simultaneous requests after reset: MEM store first, IF 3 cycles later
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0001;
    mem_addr_i = 32'h8000_0004; mem_wdata_i = 32'h0000_00a5;
    tick();
    check_bus("tie1", 32'h8000_0004, 1'b1, 4'b0001);
    check("tie1_wdata", bus_wdata_o, 32'h0000_00a5);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hdead_beef;
    tick();
    bus_ack_i = 1'b0;
    check("tie2_mem_ack", mem_ack_o, 1'b1);
    check("tie2_if_ack", if_ack_o, 1'b0);
    check("tie2_store_rdata", mem_rdata_o, 32'h0);
    mem_req_i = 1'b0;
    tick();
    check("tie3_stb", bus_stb_o, 1'b0);
    check("tie3_acks", {if_ack_o, mem_ack_o}, 2'b00);
    tick();
    check_bus("tie4", 32'h0000_0100, 1'b0, 4'hf);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    tick();
    bus_ack_i = 1'b0;
    check("tie5_if_ack", if_ack_o, 1'b1);
    check("tie5_if_rdata", if_rdata_o, 32'h1111_2222);
    if_req_i = 1'b0;
    tick();

    // Round-robin over four back-to-back ties
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hf; mem_addr_i = 32'h0000_0300;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr_stb", bus_stb_o, 1'b1);
      check("rr_grant_addr", bus_addr_o, (g % 2 == 0) ? 32'h0000_0300 : 32'h0000_0200);
      bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0a00 + 32'(g);
      tick();
      bus_ack_i = 1'b0;
      check("rr_acks", {mem_ack_o, if_ack_o}, (g % 2 == 0) ? 2'b10 : 2'b01);
      if (g == 3) begin
        if_req_i = 1'b0; mem_req_i = 1'b0;
      end
      tick();
    end
    check("rr_if_rdata", if_rdata_o, 32'h0000_0a03);
    check("rr_mem_rdata", mem_rdata_o, 32'h0000_0a02);

    // Five-cycle wait states: bus stays stable, ack one cycle after bus ack
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1100; mem_addr_i = 32'h0000_0040;
    tick();
    check_bus("ws1", 32'h0000_0040, 1'b0, 4'b1100);
    for (int c = 2; c <= 6; c++) begin
      tick();
      check_bus("ws_hold", 32'h0000_0040, 1'b0, 4'b1100);
      check("ws_no_ack", mem_ack_o, 1'b0);
      if (c == 6) begin
        bus_ack_i = 1'b1; bus_rdata_i = 32'hcafe_f00d;
      end
    end
    tick();
    bus_ack_i = 1'b0;
    check("ws7_ack", mem_ack_o, 1'b1);
    check("ws7_rdata", mem_rdata_o, 32'hcafe_f00d);
    check("ws7_stb", bus_stb_o, 1'b0);
    mem_req_i = 1'b0;
    tick();

    // Slave that never acknowledges
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hf; mem_addr_i = 32'h0000_0044;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("to_wait_stb", bus_stb_o, 1'b1);
      check("to_wait_ack", {mem_ack_o, bus_err_o}, 2'b00);
    end
    tick();
    check("to10_ack_err", {mem_ack_o, bus_err_o}, 2'b11);
    check("to10_rdata", mem_rdata_o, 32'h0);
    check("to10_stb", bus_stb_o, 1'b0);
    mem_req_i = 1'b0;
    tick();
    check("to11_ack_err", {mem_ack_o, bus_err_o}, 2'b00);
`else
    for (int c = 1; c <= 20; c++) begin
      tick();
      settle();
      check("to_wait_stb", bus_stb_o, 1'b1);
      check("to_wait_stall", stallreq_o, 1'b1);
      check("to_wait_ack", {mem_ack_o, bus_err_o}, 2'b00);
    end
    check("to_state", dbg_state, ST_BUS_MEM);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0bad_0bad;
    tick();
    bus_ack_i = 1'b0;
    check("to_late_ack", mem_ack_o, 1'b1);
    check("to_late_rdata", mem_rdata_o, 32'h0bad_0bad);
    mem_req_i = 1'b0;
    tick();
`endif

    // Reset in BUS_MEM with a coincident slave ack
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hf;
    mem_addr_i = 32'h0000_0080; mem_wdata_i = 32'h1234_5678;
    tick();
    check("mrst1_stb", bus_stb_o, 1'b1);
    rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0055;
    tick();
    check("mrst2_ack", mem_ack_o, 1'b0);
    check("mrst2_bus", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, '0);
    check("mrst2_state", dbg_state, ST_IDLE);
    check("mrst2_rdata", {if_rdata_o, mem_rdata_o}, 64'h0);
    rst = 1'b0; bus_ack_i = 1'b0; mem_req_i = 1'b0;
    tick();

    // Randomized traffic against a transaction-level model of the arbitration rules
    for (int i = 0; i < 16; i++) model_mem[i] = $urandom;
    if_pend = 0; mem_pend = 0; on_bus = 0; ack_due = 0;
    free_prev = 1; prev_if = 0; prev_mem = 0; last_mem = 0; owner_mem = 0;
    exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
    if_a = '0; m_a = '0; m_wd = '0; m_we = 0; m_sel = '0;
    for (int cyc_n = 0; cyc_n < 600; cyc_n++) begin
      tick();
      exp_if_ack  = ack_due && !owner_mem;
      exp_mem_ack = ack_due && owner_mem;
      if (ack_due) begin
        if (exp_q.size() != 0) due_data = exp_q.pop_front();
        if (owner_mem) begin
          exp_mem_rd = due_data; mem_pend = 0;
        end else begin
          exp_if_rd = due_data; if_pend = 0;
        end
      end
      check("rnd_if_ack", if_ack_o, exp_if_ack);
      check("rnd_mem_ack", mem_ack_o, exp_mem_ack);
      check("rnd_if_rdata", if_rdata_o, exp_if_rd);
      check("rnd_mem_rdata", mem_rdata_o, exp_mem_rd);
      check("rnd_err", bus_err_o, 1'b0);

      if (!on_bus && free_prev && (prev_if || prev_mem)) begin
        owner_mem = prev_mem && (!prev_if || !last_mem);
        last_mem  = owner_mem;
        on_bus    = 1;
        wait_left = $urandom_range(0, 5);
        s_addr = owner_mem ? m_a : if_a;
        s_we   = owner_mem ? m_we : 1'b0;
        s_sel  = owner_mem ? m_sel : 4'hf;
        s_wd   = m_wd;
      end
      check("rnd_stb", {bus_cyc_o, bus_stb_o}, on_bus ? 2'b11 : 2'b00);
      if (on_bus) begin
        check("rnd_addr", bus_addr_o, s_addr);
        check("rnd_we", bus_we_o, s_we);
        check("rnd_sel", bus_sel_o, s_sel);
        if (owner_mem) check("rnd_wdata", bus_wdata_o, s_wd);
      end
      free_this = !on_bus && !ack_due;
      ack_due = 0;

      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 15));
      end
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        mem_pend = 1; m_a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 15));
        m_we = 1'($urandom_range(0, 1)); m_sel = 4'($urandom_range(0, 15)); m_wd = $urandom;
      end
      if_req_i = if_pend; if_addr_i = if_a;
      mem_req_i = mem_pend; mem_we_i = m_we; mem_sel_i = m_sel;
      mem_addr_i = m_a; mem_wdata_i = m_wd;

      // Slave: byte-lane memory with random wait states and stray acks when idle
      if (on_bus) begin
        if (wait_left == 0) begin
          bus_ack_i = 1'b1;
          idx = s_addr[5:2];
          if (s_we) begin
            rd = model_mem[idx];
            for (int b = 0; b < 4; b++) if (s_sel[b]) rd[8*b +: 8] = s_wd[8*b +: 8];
            model_mem[idx] = rd;
            bus_rdata_i = $urandom;
            exp_q.push_back(32'h0);
          end else begin
            bus_rdata_i = model_mem[idx];
            exp_q.push_back(model_mem[idx]);
          end
          ack_due = 1; on_bus = 0;
        end else begin
          wait_left--;
          bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        end
      end else begin
        bus_ack_i = ($urandom_range(0, 3) == 0); bus_rdata_i = $urandom;
      end
      settle();
      check("rnd_stall", stallreq_o, (if_pend && !exp_if_ack) || (mem_pend && !exp_mem_ack));
      free_prev = free_this; prev_if = if_pend; prev_mem = mem_pend;
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-ported, Wishbone-classic-style memory bus between the instruction-fetch (IF) stage and the load/store (MEM) stage of the five-stage pipeline. It serialises accesses through a registered state machine and returns one-cycle acknowledges with read data. It raises `stallreq_o` to the pipeline control unit while any request is still outstanding. An optional watchdog aborts bus cycles that are never acknowledged.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (`DATA_W/8` byte lanes)
- `TIMEOUT_CYCLES`, 255, bus-wait limit; used only with the watchdog
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req_i`  in  1  IF read request; held until `if_ack_o`
- `if_addr_i`  in  ADDR_W  IF word address
- `if_rdata_o`  out  DATA_W  fetched instruction, valid with `if_ack_o`
- `if_ack_o`  out  1  one-cycle completion pulse
- `mem_req_i`  in  1  MEM request; held until `mem_ack_o`
- `mem_we_i`  in  1  1 = store
- `mem_sel_i`  in  DATA_W/8  byte enables
- `mem_addr_i`  in  ADDR_W  data address
- `mem_wdata_i`  in  DATA_W  store data
- `mem_rdata_o`  out  DATA_W  load data, valid with `mem_ack_o`
- `mem_ack_o`  out  1  one-cycle completion pulse
- `bus_cyc_o`, `bus_stb_o`  out  1  bus cycle / strobe, registered
- `bus_we_o`  out  1  bus write enable
- `bus_sel_o`  out  DATA_W/8  bus byte enables
- `bus_addr_o`  out  ADDR_W  bus address
- `bus_wdata_o`  out  DATA_W  bus write data
- `bus_rdata_i`  in  DATA_W  bus read data
- `bus_ack_i`  in  1  slave acknowledge
- `bus_err_o`  out  1  watchdog abort flag, pulses with the abort acknowledge
- `stallreq_o`  out  1  pipeline stall request to ctrl

## Operation
- **States:** IDLE, BUS_IF, BUS_MEM, DONE.
- **IDLE, grant decision:**
  - Only `mem_req_i` set: go to BUS_MEM.
  - Only `if_req_i` set: go to BUS_IF.
  - Both set: grant the requester not granted last. `last_grant` resets to IF, so the first tie goes to MEM.
  - Neither set: stay in IDLE.
- **On grant:** latch the requester's address, `we`, `sel` and `wdata` into the bus registers and assert `bus_cyc_o`/`bus_stb_o`.
  - IF grants drive `bus_we_o`=0 and `bus_sel_o`=all ones.
- **BUS_x:** hold all bus outputs stable until `bus_ack_i`. On ack:
  - capture `bus_rdata_i` into the granted requester's rdata register (stores capture 0);
  - drop `cyc`/`stb`;
  - update `last_grant`;
  - go to DONE.
- **DONE:** the granted requester's ack is high for exactly this cycle; next state is IDLE.
  - Requests are ignored in DONE, so the requester can update `req`/`addr` off its ack.
- **Read data:** `if_rdata_o` and `mem_rdata_o` hold their last value until overwritten.
- **Stall:** `stallreq_o` = (`if_req_i` & ~`if_ack_o`) | (`mem_req_i` & ~`mem_ack_o`), combinational.
- **Request withdrawal:** a request dropped before its grant is simply not served. Dropping a request after its grant is a protocol violation; the cycle completes anyway.

## Timing
- **Reset values:**
  - state = IDLE, `last_grant` = IF;
  - all `bus_*` outputs = 0;
  - both acks = 0, both rdata = 0, `bus_err_o` = 0.
- **Reset mid-operation:** reset wins over everything. `cyc`/`stb` go low the next edge and any `bus_ack_i` in that cycle is ignored.
- **Cycle-level latency:**
  - request seen in IDLE at cycle 0;
  - `stb` high at cycle 1;
  - `bus_ack_i` at cycle k ≥ 1;
  - requester ack at k+1;
  - IDLE at k+2.
- **Throughput:** a zero-wait slave gives a 3-cycle access and 1 access per 3 cycles.
- `bus_ack_i` is ignored outside BUS_IF/BUS_MEM.

## Configuration
- **Macro `MEM_ARB_TIMEOUT_EN`:**
  - A counter clears on entry to BUS_x and increments each BUS_x cycle without `bus_ack_i`.
  - When the counter reaches `TIMEOUT_CYCLES`, the cycle is aborted: `cyc`/`stb` drop, rdata = 0, go to DONE with the requester ack and `bus_err_o` both high for one cycle.
  - If ack and timeout coincide, the ack wins (normal completion, no error).
- **Without the macro:** `bus_err_o` is tied 0, there is no counter, and the arbiter waits indefinitely.

## Structure
- **Shared defines header:**
  - state encodings;
  - grant encodings `GrantIF`/`GrantMEM`;
  - `ZeroWord`;
  - `Stop`/`NoStop`, reused for `stallreq_o`.
- **Sub-module `mem_arb_timer`:** the watchdog counter, instantiated only under `MEM_ARB_TIMEOUT_EN`.
- Everything else lives in one module with a single registered FSM.

## Test plan
- **IF read, zero-wait slave:** `if_req`=1, addr 0x0000_0100, slave acks the same cycle as `stb` with 0x3421_0001 → `stb` at cycle 1, `if_ack_o` at cycle 2 with 0x3421_0001, `stallreq_o` high in cycles 0–1 only.
- **Simultaneous requests after reset:** IF 0x100 and MEM store (`sel`=4'b0001, addr 0x8000_0004) → MEM granted first, bus shows `we`=1 and `sel`=0001, then IF is served; `mem_ack_o` precedes `if_ack_o` by 3 cycles.
- **Round-robin:** four back-to-back tie cycles → grants alternate MEM, IF, MEM, IF.
- **Wait states:** slave acks 5 cycles after `stb` → bus outputs stay stable for all 5 cycles; ack arrives 1 cycle after `bus_ack_i`.
- **Reset mid-cycle:** `rst` asserted in BUS_MEM while `bus_ack_i`=1 → no `mem_ack_o`, all outputs 0 and state IDLE on the next edge.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never acks):** `mem_ack_o` and `bus_err_o` both pulse at cycle 10 with `mem_rdata_o`=0. Without the macro, the arbiter stays in BUS_MEM and `stallreq_o` stays high.
